ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of words out of a synchronous-read RAM onto a
// valid/ready interface, buffering through a 2-entry FIFO so stalls never lose data.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_wren,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [ADDR_WIDTH:0]   r_issue_left;
    logic [ADDR_WIDTH:0]   r_beats_left;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  r_done;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occupancy;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_zero_start;
    logic                  w_final;

    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid & i_ready;
    assign w_push   = r_inflight;

    // Occupancy the FIFO will have once the in-flight word lands and this cycle's pop retires.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_issue      = (r_state == READ) && (r_issue_left != '0) && (w_occupancy < 3'd2);
    assign w_accept     = (r_state == IDLE) && i_start && (i_len != '0);
    assign w_zero_start = (r_state == IDLE) && i_start && (i_len == '0);
    assign w_final      = (r_state == FLUSH) && w_pop && (r_beats_left == CNT_ONE);

    assign o_ram_addr = w_issue ? r_addr : r_addr_hold;
    assign o_ram_wren = 1'b0;
    assign o_data     = r_head;
    assign o_valid    = w_valid;
    assign o_last     = w_valid && (r_beats_left == CNT_ONE);
    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                if (w_issue && (r_issue_left == CNT_ONE)) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (w_final) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_addr_hold  <= '0;
            r_issue_left <= '0;
            r_beats_left <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_final || w_zero_start;
            if (w_accept) begin
                r_addr       <= i_base_addr;
                r_issue_left <= i_len;
                r_beats_left <= i_len;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + ADDR_ONE;
                    r_addr_hold  <= r_addr;
                    r_issue_left <= r_issue_left - CNT_ONE;
                end
                if (w_pop) begin
                    r_beats_left <= r_beats_left - CNT_ONE;
                end
            end
        end
    end

    // Head register feeds the output directly; tail only fills when the head is occupied and not leaving.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_ram_rdata;
                    end else begin
                        r_tail <= i_ram_rdata;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_ram_rdata;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM with mem[a]=a+1, a scoreboard
// queue of expected beats, table-driven transfers plus cycle-exact sequences.
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 6;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        bit            randReady;
    } vector_t;

    logic          clk;
    logic          rstN;
    logic          iStart;
    logic [AW-1:0] iBaseAddr;
    logic [AW:0]   iLen;
    logic [AW-1:0] oRamAddr;
    logic          oRamWren;
    logic [DW-1:0] ramRdata;
    logic [DW-1:0] oData;
    logic          oValid;
    logic          iReady;
    logic          oLast;
    logic          oBusy;
    logic          oDone;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    beat_t         expQ[$];
    int            errorCount;
    int            checkCount;
    int            beatCount;
    bit            prevStall;
    logic [DW-1:0] prevData;
    logic          prevLast;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (iStart),
        .i_base_addr (iBaseAddr),
        .i_len       (iLen),
        .o_ram_addr  (oRamAddr),
        .o_ram_wren  (oRamWren),
        .i_ram_rdata (ramRdata),
        .o_data      (oData),
        .o_valid     (oValid),
        .i_ready     (iReady),
        .o_last      (oLast),
        .o_busy      (oBusy),
        .o_done      (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ramRdata <= mem[oRamAddr];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit start, input logic [AW-1:0] base, input logic [AW:0] len);
        iStart    = start;
        iBaseAddr = base;
        iLen      = len;
    endtask

    task automatic pushExpected(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < len; i++) begin
            expQ.push_back('{data: mem[a], last: (i == len - 1)});
            a = a + 1'b1;
        end
    endtask

    // Beat monitor: handshake seen at the falling edge will transfer on the next rising edge.
    always @(negedge clk) begin
        if (!rstN) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", int'(oValid), 1);
                checkOutput("stall_data", int'(oData), int'(prevData));
                checkOutput("stall_last", int'(oLast), int'(prevLast));
            end
            if (oValid && iReady) begin
                beatCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", int'(oData), -1);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beat_data", int'(oData), int'(e.data));
                    checkOutput("beat_last", int'(oLast), int'(e.last));
                end
            end
            prevStall = oValid && !iReady;
            prevData  = oData;
            prevLast  = oLast;
        end
    end

    task automatic waitDone(input bit randReady, input int expBeats, input int beatsAtStart);
        bit gotDone;
        bit busyAtDone;
        gotDone    = 1'b0;
        busyAtDone = 1'b1;
        for (int c = 0; c < 600 && !gotDone; c++) begin
            if (randReady) iReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (oDone) begin
                gotDone    = 1'b1;
                busyAtDone = oBusy;
            end
            @(posedge clk); #1;
        end
        iReady = 1'b1;
        checkOutput("done_seen", int'(gotDone), 1);
        checkOutput("busy_at_done", int'(busyAtDone), 0);
        checkOutput("beat_count", beatCount - beatsAtStart, expBeats);
        checkOutput("queue_empty", expQ.size(), 0);
    endtask

    task automatic runTransfer(input vector_t v);
        int b0;
        b0 = beatCount;
        pushExpected(v.base, int'(v.len));
        applyStimulus(1'b1, v.base, v.len);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        waitDone(v.randReady, int'(v.len), b0);
    endtask

    vector_t vectors[7];

    initial begin
        int b0;
        bit reached;
        errorCount = 0;
        checkCount = 0;
        beatCount  = 0;
        prevStall  = 1'b0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a + 1);
        vectors[0] = '{base: 6'd4,  len: 7'd5,  randReady: 1'b0};
        vectors[1] = '{base: 6'd62, len: 7'd4,  randReady: 1'b0};
        vectors[2] = '{base: 6'd0,  len: 7'd8,  randReady: 1'b1};
        vectors[3] = '{base: 6'd20, len: 7'd1,  randReady: 1'b0};
        vectors[4] = '{base: 6'd0,  len: 7'd64, randReady: 1'b0};
        vectors[5] = '{base: 6'd33, len: 7'd3,  randReady: 1'b1};
        vectors[6] = '{base: 6'd7,  len: 7'd0,  randReady: 1'b0};

        rstN   = 1'b0;
        iReady = 1'b1;
        applyStimulus(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", int'(oValid), 0);
        checkOutput("rst_busy", int'(oBusy), 0);
        checkOutput("rst_done", int'(oDone), 0);
        checkOutput("rst_addr", int'(oRamAddr), 0);
        checkOutput("rst_wren", int'(oRamWren), 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Cycle-exact latency and busy/done window: base=4, len=5.
        b0 = beatCount;
        pushExpected(6'd4, 5);
        applyStimulus(1'b1, 6'd4, 7'd5);
        for (int cyc = 0; cyc <= 9; cyc++) begin
            @(negedge clk);
            checkOutput($sformatf("lat_valid_c%0d", cyc), int'(oValid), int'(cyc >= 3 && cyc <= 7));
            checkOutput($sformatf("lat_busy_c%0d", cyc), int'(oBusy), int'(cyc >= 1 && cyc <= 7));
            checkOutput($sformatf("lat_done_c%0d", cyc), int'(oDone), int'(cyc == 8));
            if (cyc == 1) checkOutput("lat_addr_c1", int'(oRamAddr), 4);
            @(posedge clk); #1;
            if (cyc == 0) applyStimulus(1'b0, '0, '0);
        end
        checkOutput("lat_beats", beatCount - b0, 5);

        // Address wrap: base=62, len=4.
        b0 = beatCount;
        pushExpected(6'd62, 4);
        applyStimulus(1'b1, 6'd62, 7'd4);
        for (int cyc = 0; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc >= 1) checkOutput($sformatf("wrap_addr_c%0d", cyc), int'(oRamAddr), (61 + cyc) % 64);
            @(posedge clk); #1;
            if (cyc == 0) applyStimulus(1'b0, '0, '0);
        end
        waitDone(1'b0, 4, b0);

        // Zero-length start: done in cycle 1, never busy.
        applyStimulus(1'b1, 6'd9, 7'd0);
        @(negedge clk);
        checkOutput("zero_busy_c0", int'(oBusy), 0);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("zero_done_c1", int'(oDone), 1);
        checkOutput("zero_busy_c1", int'(oBusy), 0);
        checkOutput("zero_valid_c1", int'(oValid), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) runTransfer(vectors[i]);

        // Start pulses while busy must be ignored.
        b0 = beatCount;
        pushExpected(6'd10, 6);
        applyStimulus(1'b1, 6'd10, 7'd6);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 6'd40, 7'd3);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        waitDone(1'b0, 6, b0);

        // Reset mid-transfer after beat 2 of len=10.
        b0 = beatCount;
        pushExpected(6'd0, 10);
        applyStimulus(1'b1, 6'd0, 7'd10);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            if (beatCount - b0 >= 2) reached = 1'b1;
        end
        checkOutput("rst_mid_reached", int'(reached), 1);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checkOutput("rstmid_valid", int'(oValid), 0);
        checkOutput("rstmid_last", int'(oLast), 0);
        checkOutput("rstmid_busy", int'(oBusy), 0);
        checkOutput("rstmid_done", int'(oDone), 0);
        checkOutput("rstmid_addr", int'(oRamAddr), 0);
        checkOutput("rstmid_data", int'(oData), 0);
        checkOutput("rstmid_wren", int'(oRamWren), 0);
        expQ.delete();
        @(posedge clk); #1;
        checkOutput("rstmid_hold_done", int'(oDone), 0);
        rstN = 1'b1;
        b0 = beatCount;
        pushExpected(6'd0, 2);
        applyStimulus(1'b1, 6'd0, 7'd2);
        @(negedge clk);
        checkOutput("rstrel_done", int'(oDone), 0);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0);
        checkOutput("rstrel_busy", int'(oBusy), 1);
        waitDone(1'b0, 2, b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
